// File: rtl/vend_pkg.sv
// Shared types and constants for the vending machine change path.
// Coin values are expressed in nickel units.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        PULSE,
        GAP,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE,
        COIN_Q,
        COIN_D,
        COIN_N
    } coin_sel_t;

    localparam int QUARTER = 5;
    localparam int DIME    = 2;
    localparam int NICKEL  = 1;

endpackage

// File: rtl/change_dispenser_timer.sv
// Loadable down-counter with a single-cycle expire flag.
// Loading len holds the owner for len+1 cycles before expire is seen.
module cycle_timer #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] len,
    output logic          expire
);

    logic [TW-1:0] cnt;
    logic          armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (load) begin
            cnt   <= len;
            armed <= 1'b1;
        end else if (armed) begin
            if (cnt == '0) begin
                armed <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign expire = armed && (cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy coin dispenser: pays a change amount one coin at a time, largest
// coin first, skipping empty tubes, with fixed pulse and gap durations.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W        = 4,
    parameter int PULSE_CYCLES = 25000000,
    parameter int GAP_CYCLES   = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [AMT_W-1:0] amount,
    input  logic             q_empty,
    input  logic             d_empty,
    input  logic             n_empty,
    output logic             busy,
    output logic             coin_q,
    output logic             coin_d,
    output logic             coin_n,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remaining
);

    localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW      = $clog2(MAX_CYC) + 1;

    // Timer is loaded with length-1 so the state lasts exactly length cycles.
    localparam logic [TW-1:0]    P_LEN = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0]    G_LEN = TW'(GAP_CYCLES - 1);
    localparam logic [AMT_W-1:0] V_Q   = AMT_W'(QUARTER);
    localparam logic [AMT_W-1:0] V_D   = AMT_W'(DIME);
    localparam logic [AMT_W-1:0] V_N   = AMT_W'(NICKEL);

    state_t            state, state_nxt;
    coin_sel_t         sel, sel_nxt;
    logic [AMT_W-1:0]  rem_nxt;
    logic              short_nxt;
    logic              tmr_load;
    logic [TW-1:0]     tmr_len;
    logic              tmr_expire;

    cycle_timer #(.TW(TW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .len    (tmr_len),
        .expire (tmr_expire)
    );

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        rem_nxt   = remaining;
        short_nxt = 1'b0;
        tmr_load  = 1'b0;
        tmr_len   = P_LEN;
        case (state)
            IDLE: begin
                if (req) begin
                    rem_nxt   = amount;
                    state_nxt = SELECT;
                end
            end
            SELECT: begin
                tmr_len = P_LEN;
                if (remaining >= V_Q && !q_empty) begin
                    sel_nxt   = COIN_Q;
                    rem_nxt   = remaining - V_Q;
                    tmr_load  = 1'b1;
                    state_nxt = PULSE;
                end else if (remaining >= V_D && !d_empty) begin
                    sel_nxt   = COIN_D;
                    rem_nxt   = remaining - V_D;
                    tmr_load  = 1'b1;
                    state_nxt = PULSE;
                end else if (remaining >= V_N && !n_empty) begin
                    sel_nxt   = COIN_N;
                    rem_nxt   = remaining - V_N;
                    tmr_load  = 1'b1;
                    state_nxt = PULSE;
                end else begin
                    // Either fully paid or stuck with no usable tube.
                    sel_nxt   = COIN_NONE;
                    short_nxt = (remaining != '0);
                    state_nxt = DONE;
                end
            end
            PULSE: begin
                if (tmr_expire) begin
                    tmr_load  = 1'b1;
                    tmr_len   = G_LEN;
                    sel_nxt   = COIN_NONE;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (tmr_expire) begin
                    state_nxt = SELECT;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= COIN_NONE;
            remaining <= '0;
            busy      <= 1'b0;
            coin_q    <= 1'b0;
            coin_d    <= 1'b0;
            coin_n    <= 1'b0;
            done      <= 1'b0;
            short     <= 1'b0;
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            remaining <= rem_nxt;
            busy      <= (state_nxt != IDLE);
            coin_q    <= (state_nxt == PULSE) && (sel_nxt == COIN_Q);
            coin_d    <= (state_nxt == PULSE) && (sel_nxt == COIN_D);
            coin_n    <= (state_nxt == PULSE) && (sel_nxt == COIN_N);
            done      <= (state_nxt == DONE);
            short     <= short_nxt;
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with PULSE_CYCLES=3, GAP_CYCLES=2,
// so each dispensed coin costs 6 cycles and done lands at 6*n+2.
module tb_change_dispenser;

    logic       clk;
    logic       rst;
    logic       req;
    logic [3:0] amount;
    logic       q_empty;
    logic       d_empty;
    logic       n_empty;
    logic       busy;
    logic       coin_q;
    logic       coin_d;
    logic       coin_n;
    logic       done;
    logic       short;
    logic [3:0] remaining;

    int checks;
    int failures;

    int r_seq, r_coins, r_high, r_onehot_err, r_timing_err;
    int r_done_cyc, r_done_cnt, r_short, r_rem, r_busy1, r_busy_after;

    change_dispenser #(
        .AMT_W        (4),
        .PULSE_CYCLES (3),
        .GAP_CYCLES   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .amount    (amount),
        .q_empty   (q_empty),
        .d_empty   (d_empty),
        .n_empty   (n_empty),
        .busy      (busy),
        .coin_q    (coin_q),
        .coin_d    (coin_d),
        .coin_n    (coin_n),
        .done      (done),
        .short     (short),
        .remaining (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Issues a request at the current negedge and observes until the cycle after done.
    // Cycle c is the interval after edge c-1; extra req pulses are driven in cycles xr1..xr3.
    task automatic run_req(input int amt, input logic qe, input logic de, input logic ne,
                           input int xr1, input int xr2, input int xr3);
        logic pq, pd, pn;
        bit   seen;
        int   code;
        r_seq = 0; r_coins = 0; r_high = 0; r_onehot_err = 0; r_timing_err = 0;
        r_done_cyc = -1; r_done_cnt = 0; r_short = -1; r_rem = -1;
        r_busy1 = -1; r_busy_after = -1;
        q_empty = qe; d_empty = de; n_empty = ne;
        amount = 4'(amt);
        req = 1'b1;
        @(posedge clk);
        pq = 1'b0; pd = 1'b0; pn = 1'b0; seen = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            req = (cyc == xr1) || (cyc == xr2) || (cyc == xr3);
            if (cyc == 1) r_busy1 = int'(busy);
            if (int'(coin_q) + int'(coin_d) + int'(coin_n) > 1) r_onehot_err++;
            r_high += int'(coin_q) + int'(coin_d) + int'(coin_n);
            code = 0;
            if (coin_q && !pq) code = 1;
            else if (coin_d && !pd) code = 2;
            else if (coin_n && !pn) code = 3;
            if (code != 0) begin
                r_seq = r_seq * 10 + code;
                if (cyc != 2 + 6 * r_coins) r_timing_err++;
                r_coins++;
            end
            pq = coin_q; pd = coin_d; pn = coin_n;
            if (done) begin
                r_done_cnt++;
                if (!seen) begin
                    r_done_cyc = cyc;
                    r_short    = int'(short);
                    r_rem      = int'(remaining);
                end
                seen = 1'b1;
            end else if (seen) begin
                r_busy_after = int'(busy);
                break;
            end
        end
        req = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0; req = 1'b0; amount = '0;
        q_empty = 1'b0; d_empty = 1'b0; n_empty = 1'b0;

        // Reset takes effect before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("reset_outputs", int'({busy, coin_q, coin_d, coin_n, done, short, remaining}), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // amount=8, all tubes full: Q, D, N
        run_req(8, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        chk("a8_seq", r_seq, 123);
        chk("a8_high_cycles", r_high, 9);
        chk("a8_timing", r_timing_err, 0);
        chk("a8_onehot", r_onehot_err, 0);
        chk("a8_done_cyc", r_done_cyc, 20);
        chk("a8_short", r_short, 0);
        chk("a8_remaining", r_rem, 0);
        chk("a8_busy1", r_busy1, 1);
        chk("a8_busy_after", r_busy_after, 0);

        // amount=0: immediate done
        run_req(0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        chk("a0_coins", r_coins, 0);
        chk("a0_done_cyc", r_done_cyc, 2);
        chk("a0_short", r_short, 0);
        chk("a0_busy1", r_busy1, 1);
        chk("a0_busy_after", r_busy_after, 0);

        // amount=6 with quarters empty: three dimes
        run_req(6, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        chk("a6q_seq", r_seq, 222);
        chk("a6q_done_cyc", r_done_cyc, 20);
        chk("a6q_short", r_short, 0);
        chk("a6q_remaining", r_rem, 0);

        // amount=5, quarters and nickels empty: two dimes then shortfall of 1
        run_req(5, 1'b1, 1'b0, 1'b1, 0, 0, 0);
        chk("a5qn_seq", r_seq, 22);
        chk("a5qn_done_cyc", r_done_cyc, 14);
        chk("a5qn_short", r_short, 1);
        chk("a5qn_remaining", r_rem, 1);

        // amount=1, nickels empty: short even though dimes exist
        run_req(1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        chk("a1n_coins", r_coins, 0);
        chk("a1n_done_cyc", r_done_cyc, 2);
        chk("a1n_short", r_short, 1);
        chk("a1n_remaining", r_rem, 1);

        // Extra req during PULSE (cycle 3), GAP (cycle 6) and DONE (cycle 8) is ignored
        run_req(5, 1'b0, 1'b0, 1'b0, 3, 6, 8);
        chk("ign_seq", r_seq, 1);
        chk("ign_done_cyc", r_done_cyc, 8);
        chk("ign_done_cnt", r_done_cnt, 1);
        chk("ign_busy_after", r_busy_after, 0);
        // Issued in the first IDLE cycle after done
        run_req(2, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        chk("next_seq", r_seq, 2);
        chk("next_done_cyc", r_done_cyc, 8);
        chk("next_short", r_short, 0);

        // Reset in the middle of a quarter pulse
        q_empty = 1'b0; d_empty = 1'b0; n_empty = 1'b0;
        amount = 4'd5;
        req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_coin_q_before", int'(coin_q), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_coin_q_after", int'(coin_q), 0);
        chk("midrst_busy_after", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int dcnt;
            dcnt = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (done || busy || coin_q || coin_d || coin_n) dcnt++;
            end
            chk("midrst_quiet", dcnt, 0);
        end
        run_req(8, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        chk("post_rst_seq", r_seq, 123);
        chk("post_rst_done_cyc", r_done_cyc, 20);
        chk("post_rst_short", r_short, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
